instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: word-addressed instruction fetch with a small prefetch FIFO.
// Optional feature macro IF_PREFETCH_EN: when defined the FIFO holds two
// entries, which allows back-to-back fetch. When undefined it holds one entry,
// and no new request is issued while that entry is held.
// fsm_state exposes the fetch FSM (0 IDLE, 1 REQ, 2 FLUSH) for debug.
//
// Memory handshake: the unit raises imem_req with imem_addr. It keeps both
// stable until a rising edge where imem_ack=1. On that edge imem_rdata is
// the word at imem_addr. At most one request is outstanding, and imem_ack
// has no effect while imem_req=0.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        stall_mem_ready,
    input  logic        branch_taken,
    input  logic [5:0]  branch_offset_imm,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic [1:0]  fsm_state
);

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] pc_q, pc_n;          // address of the next request to issue
    logic        req_q, req_n;
    logic [15:0] addr_q, addr_n;
    logic [1:0]  count_q, count_n;
    logic [15:0] fifo_pc    [DEPTH];  // entry 0 is the head
    logic [15:0] fifo_instr [DEPTH];

    logic        ack_hs;
    logic        redirect;
    logic        pop;
    logic        push;
    logic [15:0] target;
    logic [1:0]  wr_idx;

    assign instr_valid = (count_q != 2'd0);
    assign instr_out   = instr_valid ? fifo_instr[0] : 16'h0000;
    assign instr_pc    = instr_valid ? fifo_pc[0]    : 16'h0000;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fsm_state   = state_q;

    assign ack_hs   = req_q & imem_ack;
    // A freeze blocks both consuming and redirecting. A taken branch wins over stall.
    assign redirect = instr_valid & branch_taken & ~stall_mem_ready;
    assign pop      = instr_valid & ~stall & ~stall_mem_ready & ~branch_taken;
    assign target   = fifo_pc[0] + 16'd1 + {{10{branch_offset_imm[5]}}, branch_offset_imm};
    assign wr_idx   = count_q - {1'b0, pop};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state, next request, FIFO occupancy and fetch PC
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        req_n   = req_q;
        addr_n  = addr_q;
        count_n = count_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                state_n = REQ;
                req_n   = 1'b1;
                addr_n  = pc_q;
            end
            REQ: begin
                if (redirect) begin
                    // Flush the queue. Any data acked on this edge belongs to the old path.
                    count_n = 2'd0;
                    pc_n    = target;
                    if (req_q && !imem_ack) begin
                        state_n = FLUSH;   // keep the old request until it completes
                    end else begin
                        req_n  = 1'b1;
                        addr_n = target;
                    end
                end else begin
                    push    = ack_hs;
                    if (ack_hs) begin
                        pc_n = addr_q + 16'd1;
                    end
                    count_n = count_q + {1'b0, push} - {1'b0, pop};
                    // Issue the next request only when there is room for its data.
                    if (ack_hs || !req_q) begin
                        req_n  = (count_n < DEPTH_C);
                        addr_n = pc_n;
                    end
                end
            end
            FLUSH: begin
                if (ack_hs) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = pc_q;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    // Fetch PC, request registers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= 16'h0000;
            req_q   <= 1'b0;
            addr_q  <= 16'h0000;
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            count_q <= count_n;
        end
    end

    // FIFO storage: a pop slides entry DEPTH-1 into the head (DEPTH is 1 or 2),
    // and a push writes behind the last entry that remains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= 16'h0000;
                fifo_instr[i] <= 16'h0000;
            end
        end else begin
            if (pop) begin
                fifo_pc[0]    <= fifo_pc[DEPTH-1];
                fifo_instr[0] <= fifo_instr[DEPTH-1];
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == 2'(i)) begin
                        fifo_pc[i]    <= addr_q;
                        fifo_instr[i] <= imem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit.
// The reference model is the program-order stream. exp_pc is the pc that decode
// must see next. It advances by one on a consume and jumps on a taken branch.
// Memory returns mem_word(addr) for every address.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        stall_mem_ready;
    logic        branch_taken;
    logic [5:0]  branch_offset_imm;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic [1:0]  fsm_state;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_mode = 0;   // 0: ack held high, 1: random ack, 2: ack held low
    logic [15:0] exp_pc   = 16'h0000;
    logic [15:0] exp_q[$];

    instr_fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .stall_mem_ready   (stall_mem_ready),
        .branch_taken      (branch_taken),
        .branch_offset_imm (branch_offset_imm),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .instr_out         (instr_out),
        .instr_pc          (instr_pc),
        .instr_valid       (instr_valid),
        .fsm_state         (fsm_state)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench did not complete");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // memory driver: updates ack/data on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            case (ack_mode)
                0:       imem_ack = 1'b1;
                1:       imem_ack = ($urandom_range(0, 1) == 1);
                default: imem_ack = 1'b0;
            endcase
            imem_rdata = imem_ack ? mem_word(imem_addr) : 16'hDEAD;
        end
    end

    // request-hold monitor: an unacked request must keep req and addr
    initial begin
        logic        p_req;
        logic        p_ack;
        logic        p_rst;
        logic [15:0] p_addr;
        forever begin
            @(negedge clk);
            #2;
            p_req  = imem_req;
            p_ack  = imem_ack;
            p_addr = imem_addr;
            p_rst  = rst;
            @(posedge clk);
            #1;
            if (p_rst === 1'b1 && rst === 1'b1 && p_req === 1'b1 && p_ack === 1'b0) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    n_fail++;
                    $display("FAIL req_hold got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, p_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: apply the decode inputs for the coming edge
    task automatic model_edge(input logic v);
        if (v && !stall_mem_ready && branch_taken)
            exp_pc = exp_pc + 16'd1 + {{10{branch_offset_imm[5]}}, branch_offset_imm};
        else if (v && !stall_mem_ready && !stall)
            exp_pc = exp_pc + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; stall_mem_ready = 1'b0; branch_taken = 1'b0;
        branch_offset_imm = 6'd0; ack_mode = 0;
        repeat (3) tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b want=0", imem_req); end
        n_checks++; if (imem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h want=0000", imem_addr); end
        n_checks++; if (instr_out !== 16'h0) begin n_fail++; $display("FAIL reset_instr got=%h want=0000", instr_out); end
        n_checks++; if (instr_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc got=%h want=0000", instr_pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d want=%0d", fsm_state, ST_IDLE); end
    endtask

    task automatic test_sequential();
        int got;
        int want;
        got = 0;
        exp_q = {};
        for (int i = 0; i < 24; i++) exp_q.push_back(16'h1000 + 16'(i));
        exp_pc = 16'h0000;
        rst = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            model_edge(instr_valid);
            tick();
            if (c == 1) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
                    n_fail++; $display("FAIL seq_first_req got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr_out !== 16'h1000) begin
                    n_fail++; $display("FAIL seq_first_instr got valid=%b instr=%h want valid=1 instr=1000", instr_valid, instr_out);
                end
            end
`ifdef IF_PREFETCH_EN
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(c - 1)) begin
                n_fail++; $display("FAIL seq_addr cycle=%0d got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, 16'(c - 1));
            end
            if (c >= 2) begin
                n_checks++;
                if (instr_valid !== 1'b1) begin
                    n_fail++; $display("FAIL seq_rate cycle=%0d got valid=%b want 1", c, instr_valid);
                end
            end
`endif
            if (instr_valid === 1'b1 && exp_q.size() > 0) begin
                n_checks++;
                if (instr_out !== exp_q[0] || instr_pc !== exp_pc) begin
                    n_fail++; $display("FAIL seq_stream got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr_out, exp_pc, exp_q[0]);
                end
                void'(exp_q.pop_front());
                got++;
            end
        end
`ifdef IF_PREFETCH_EN
        want = 19;
`else
        want = 10;
`endif
        n_checks++;
        if (got != want) begin n_fail++; $display("FAIL seq_count got=%0d want=%0d", got, want); end
    endtask

    task automatic test_stall();
        int got;
        int want;
        got = 0;
        stall = 1'b0;
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) begin
            model_edge(instr_valid);
            tick();
        end
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            model_edge(instr_valid);
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
                n_fail++; $display("FAIL stall_hold got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h",
                                   instr_valid, instr_pc, instr_out, exp_pc, mem_word(exp_pc));
            end
        end
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop got=%b want=0", imem_req); end
        stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            model_edge(instr_valid);
            tick();
            if (instr_valid === 1'b1) begin
                got++;
                n_checks++;
                if (instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL stall_resume got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr_out, exp_pc, mem_word(exp_pc));
                end
            end
        end
`ifdef IF_PREFETCH_EN
        want = 16;
`else
        want = 8;
`endif
        n_checks++;
        if (got != want) begin n_fail++; $display("FAIL stall_resume_count got=%0d want=%0d", got, want); end
    endtask

    task automatic test_branch();
        int off;
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) begin
            model_edge(instr_valid);
            tick();
        end
        off = 16 - (int'(exp_pc) + 1);
        n_checks++;
        if (off < -32 || off > 31) begin n_fail++; $display("FAIL branch_setup got offset=%0d want -32..31", off); end
        branch_taken = 1'b1;
        branch_offset_imm = 6'(off);
        model_edge(instr_valid);
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 8 && instr_valid !== 1'b1; i++) begin
            model_edge(instr_valid);
            tick();
        end
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0010 || instr_out !== mem_word(16'h0010)) begin
            n_fail++; $display("FAIL branch_head got valid=%b pc=%h instr=%h want valid=1 pc=0010 instr=%h",
                               instr_valid, instr_pc, instr_out, mem_word(16'h0010));
        end
        branch_taken = 1'b1;
        branch_offset_imm = 6'b111110;
        model_edge(instr_valid);
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h000F) begin
            n_fail++; $display("FAIL branch_target got req=%b addr=%h want req=1 addr=000f", imem_req, imem_addr);
        end
        n_checks++;
        if (instr_valid !== 1'b0 || instr_out !== 16'h0000) begin
            n_fail++; $display("FAIL branch_flush got valid=%b instr=%h want valid=0 instr=0000", instr_valid, instr_out);
        end
        branch_taken = 1'b0;
        model_edge(instr_valid);
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
            n_fail++; $display("FAIL branch_first got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h",
                               instr_valid, instr_pc, instr_out, exp_pc, mem_word(exp_pc));
        end
    endtask

    task automatic test_flush();
`ifdef IF_PREFETCH_EN
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            model_edge(instr_valid);
            tick();
            if (instr_valid === 1'b1) begin
                n_checks++;
                if (instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL flush_stream got pc=%h instr=%h want pc=%h", instr_pc, instr_out, exp_pc);
                end
            end
            if (imem_req === 1'b1 && imem_addr === 16'h0020) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL flush_setup got found=%b want 1", found); end
        ack_mode = 2;
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            model_edge(instr_valid);
            tick();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0020 || fsm_state !== ST_REQ) begin
                n_fail++; $display("FAIL flush_wait got req=%b addr=%h state=%0d want req=1 addr=0020 state=%0d",
                                   imem_req, imem_addr, fsm_state, ST_REQ);
            end
        end
        branch_taken = 1'b1;
        branch_offset_imm = 6'd5;
        model_edge(instr_valid);
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        n_checks++;
        if (fsm_state !== ST_FLUSH || imem_req !== 1'b1 || imem_addr !== 16'h0020 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_enter got state=%0d req=%b addr=%h valid=%b want state=%0d req=1 addr=0020 valid=0",
                               fsm_state, imem_req, imem_addr, instr_valid, ST_FLUSH);
        end
        model_edge(instr_valid);
        tick();
        ack_mode = 0;
        model_edge(instr_valid);
        tick();
        n_checks++;
        if (fsm_state !== ST_REQ || imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_target got state=%0d req=%b addr=%h valid=%b want state=%0d req=1 addr=%h valid=0",
                               fsm_state, imem_req, imem_addr, instr_valid, ST_REQ, exp_pc);
        end
        model_edge(instr_valid);
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
            n_fail++; $display("FAIL flush_first got valid=%b pc=%h instr=%h want valid=1 pc=%h", instr_valid, instr_pc, instr_out, exp_pc);
        end
`endif
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) begin
            model_edge(instr_valid);
            tick();
        end
        stall_mem_ready = 1'b1;
        branch_taken = 1'b1;
        branch_offset_imm = 6'd3;
        for (int s = 0; s < 3; s++) begin
            model_edge(instr_valid);
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
                n_fail++; $display("FAIL freeze_hold got valid=%b pc=%h instr=%h want valid=1 pc=%h", instr_valid, instr_pc, instr_out, exp_pc);
            end
        end
`ifdef IF_PREFETCH_EN
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL freeze_buffered got req=%b want=0", imem_req); end
`endif
        stall_mem_ready = 1'b0;
        model_edge(instr_valid);
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL freeze_redirect got req=%b addr=%h valid=%b want req=1 addr=%h valid=0", imem_req, imem_addr, instr_valid, exp_pc);
        end
        branch_taken = 1'b0;
        stall_mem_ready = 1'b1;
        model_edge(instr_valid);
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
            n_fail++; $display("FAIL freeze_ack_push got valid=%b pc=%h instr=%h want valid=1 pc=%h", instr_valid, instr_pc, instr_out, exp_pc);
        end
        stall_mem_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int got;
        got = 0;
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
            model_edge(instr_valid);
            tick();
        end
        ack_mode = 2;
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0 || instr_out !== 16'h0 || instr_pc !== 16'h0 ||
            instr_valid !== 1'b0 || fsm_state !== ST_IDLE) begin
            n_fail++; $display("FAIL async_reset got req=%b addr=%h instr=%h pc=%h valid=%b state=%0d want all zero",
                               imem_req, imem_addr, instr_out, instr_pc, instr_valid, fsm_state);
        end
        ack_mode = 0;
        tick();
        tick();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ignore_ack got req=%b valid=%b want req=0 valid=0", imem_req, instr_valid);
        end
        exp_pc = 16'h0000;
        rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            model_edge(instr_valid);
            tick();
            if (c == 1) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
                    n_fail++; $display("FAIL restart_req got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
                end
            end
            if (instr_valid === 1'b1) begin
                got++;
                n_checks++;
                if (instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL restart_stream got pc=%h instr=%h want pc=%h", instr_pc, instr_out, exp_pc);
                end
            end
        end
        n_checks++;
        if (got < 3) begin n_fail++; $display("FAIL restart_count got=%0d want>=3", got); end
    endtask

    task automatic test_random();
        int got;
        int idle_run;
        got = 0;
        idle_run = 0;
        ack_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            stall             = ($urandom_range(0, 99) < 25);
            stall_mem_ready   = ($urandom_range(0, 99) < 10);
            branch_taken      = ($urandom_range(0, 99) < 8);
            branch_offset_imm = 6'($urandom_range(0, 63));
            model_edge(instr_valid);
            tick();
            n_checks++;
            if (instr_valid === 1'b1) begin
                got++;
                idle_run = 0;
                if (instr_pc !== exp_pc || instr_out !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL random_stream cycle=%0d got pc=%h instr=%h want pc=%h instr=%h",
                                       c, instr_pc, instr_out, exp_pc, mem_word(exp_pc));
                end
            end else begin
                idle_run++;
                if (instr_out !== 16'h0000) begin
                    n_fail++; $display("FAIL random_empty_nop cycle=%0d got instr=%h want 0000", c, instr_out);
                end
            end
            if (idle_run > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL random_liveness cycle=%0d got %0d empty cycles want <=40", c, idle_run);
                break;
            end
        end
        stall = 1'b0; stall_mem_ready = 1'b0; branch_taken = 1'b0;
        n_checks++;
        if (got < 150) begin n_fail++; $display("FAIL random_throughput got=%0d want>=150", got); end
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        stall_mem_ready = 1'b0;
        branch_taken = 1'b0;
        branch_offset_imm = 6'd0;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush();
        test_freeze();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
